// File: rtl/fxu_pkg.sv
// Shared widths, operand types and opcode constants for the FXU scheduler.
package fxu_pkg;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 16;
  localparam int OP_W   = 4;
  localparam int PC_W   = 16;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [OP_W-1:0]   op_t;
  typedef logic [PC_W-1:0]   pc_t;

  localparam op_t OP_MOV = 4'd0;
  localparam op_t OP_ADD = 4'd1;
  localparam op_t OP_JEQ = 4'd6;

  // True when a pending operand is satisfied by the current result broadcast.
  function automatic logic operand_hit(input logic busy, input tag_t tag,
                                       input logic cdb_valid, input tag_t cdb_rs_num);
    return busy && cdb_valid && (tag == cdb_rs_num);
  endfunction

endpackage

// File: rtl/fxu_rs_entry.sv
// One reservation-station entry: holds an instruction and its two operands,
// captures operands from the result bus at dispatch (bypass) or while waiting
// (wakeup), and reports when it is ready to issue.
module fxu_rs_entry
  import fxu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  flush,
  input  logic  alloc,
  input  logic  free,
  input  op_t   d_op,
  input  pc_t   d_pc,
  input  logic  d_busy0,
  input  tag_t  d_tag0,
  input  data_t d_val0,
  input  logic  d_busy1,
  input  tag_t  d_tag1,
  input  data_t d_val1,
  input  logic  cdb_valid,
  input  tag_t  cdb_rs_num,
  input  data_t cdb_val,
  output logic  valid,
  output logic  ready,
  output op_t   op,
  output pc_t   pc,
  output data_t val0,
  output data_t val1
);

  logic  valid_reg;
  op_t   op_reg;
  pc_t   pc_reg;
  logic  busy0_reg;
  tag_t  tag0_reg;
  data_t val0_reg;
  logic  busy1_reg;
  tag_t  tag1_reg;
  data_t val1_reg;

  logic bypass0;
  logic bypass1;
  logic wake0;
  logic wake1;

  assign bypass0 = operand_hit(d_busy0, d_tag0, cdb_valid, cdb_rs_num);
  assign bypass1 = operand_hit(d_busy1, d_tag1, cdb_valid, cdb_rs_num);
  assign wake0   = valid_reg && operand_hit(busy0_reg, tag0_reg, cdb_valid, cdb_rs_num);
  assign wake1   = valid_reg && operand_hit(busy1_reg, tag1_reg, cdb_valid, cdb_rs_num);

  // Entry storage: flush wins, then allocation, otherwise issue-free and wakeup.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      op_reg    <= '0;
      pc_reg    <= '0;
      busy0_reg <= 1'b0;
      tag0_reg  <= '0;
      val0_reg  <= '0;
      busy1_reg <= 1'b0;
      tag1_reg  <= '0;
      val1_reg  <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (alloc) begin
      valid_reg <= 1'b1;
      op_reg    <= d_op;
      pc_reg    <= d_pc;
      busy0_reg <= d_busy0 && !bypass0;
      tag0_reg  <= d_tag0;
      val0_reg  <= bypass0 ? cdb_val : d_val0;
      busy1_reg <= d_busy1 && !bypass1;
      tag1_reg  <= d_tag1;
      val1_reg  <= bypass1 ? cdb_val : d_val1;
    end else begin
      if (free) begin
        valid_reg <= 1'b0;
      end
      if (wake0) begin
        busy0_reg <= 1'b0;
        val0_reg  <= cdb_val;
      end
      if (wake1) begin
        busy1_reg <= 1'b0;
        val1_reg  <= cdb_val;
      end
    end
  end

  // MOV only reads operand 0, so a pending operand 1 does not block it.
  assign ready = valid_reg && !busy0_reg && (!busy1_reg || (op_reg == OP_MOV));
  assign valid = valid_reg;
  assign op    = op_reg;
  assign pc    = pc_reg;
  assign val0  = val0_reg;
  assign val1  = val1_reg;

endmodule

// File: rtl/fxu_sched.sv
// FXU scheduler: allocates reservation-station entries, tracks their dispatch
// age, selects the oldest ready entry and issues it through registered x_*.
module fxu_sched
  import fxu_pkg::*;
#(
  parameter int N_ENTRIES = 4,
  parameter int RS_BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              d_valid,
  input  logic [OP_W-1:0]   d_op,
  input  logic [PC_W-1:0]   d_pc,
  input  logic              d_busy0,
  input  logic              d_busy1,
  input  logic [TAG_W-1:0]  d_tag0,
  input  logic [TAG_W-1:0]  d_tag1,
  input  logic [DATA_W-1:0] d_val0,
  input  logic [DATA_W-1:0] d_val1,
  output logic              full,
  output logic [TAG_W-1:0]  d_rs_num,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_rs_num,
  input  logic [DATA_W-1:0] cdb_val,
  input  logic              fxu_busy,
  output logic              x_valid,
  output logic [TAG_W-1:0]  x_rs_num,
  output logic [OP_W-1:0]   x_op,
  output logic [PC_W-1:0]   x_pc,
  output logic [DATA_W-1:0] x_val0,
  output logic [DATA_W-1:0] x_val1
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  logic [N_ENTRIES-1:0] valid_vec;
  logic [N_ENTRIES-1:0] ready_vec;
  op_t                  op_arr   [N_ENTRIES];
  pc_t                  pc_arr   [N_ENTRIES];
  data_t                val0_arr [N_ENTRIES];
  data_t                val1_arr [N_ENTRIES];

  // Age rank: 0 is the oldest valid entry; valid entries always hold distinct ranks.
  logic [IDX_W-1:0] rank_reg  [N_ENTRIES];
  logic [IDX_W-1:0] rank_next [N_ENTRIES];

  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] sel_rank;
  logic             sel_found;
  logic [CNT_W-1:0] valid_cnt;
  logic [CNT_W-1:0] new_rank;
  logic             dispatch_fire;
  logic             issue_fire;

  logic             x_valid_reg;
  tag_t             x_rs_num_reg;
  op_t              x_op_reg;
  pc_t              x_pc_reg;
  data_t            x_val0_reg;
  data_t            x_val1_reg;

  assign full          = &valid_vec;
  assign dispatch_fire = d_valid && !full && !flush;
  assign issue_fire    = sel_found && !fxu_busy && !flush;
  assign d_rs_num      = TAG_W'(RS_BASE) + TAG_W'(alloc_idx);

  // Lowest-index free entry (scan downward so the lowest one wins).
  always_comb begin
    alloc_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        alloc_idx = IDX_W'(i);
      end
    end
  end

  // Oldest ready entry by age rank, plus the current occupancy count.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_rank  = '0;
    valid_cnt = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      valid_cnt = valid_cnt + CNT_W'(valid_vec[i]);
      if (ready_vec[i] && (!sel_found || (rank_reg[i] < sel_rank))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_rank  = rank_reg[i];
      end
    end
  end

  // Rank update: younger entries close the gap left by an issue; a new entry
  // goes behind every entry that survives this edge.
  always_comb begin
    new_rank = valid_cnt - CNT_W'(issue_fire);
    for (int i = 0; i < N_ENTRIES; i++) begin
      rank_next[i] = rank_reg[i];
      if (issue_fire && valid_vec[i] && (rank_reg[i] > sel_rank)) begin
        rank_next[i] = rank_reg[i] - 1'b1;
      end
      if (dispatch_fire && (alloc_idx == IDX_W'(i))) begin
        rank_next[i] = IDX_W'(new_rank);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
      fxu_rs_entry u_entry (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .alloc      (dispatch_fire && (alloc_idx == IDX_W'(gi))),
        .free       (issue_fire && (sel_idx == IDX_W'(gi))),
        .d_op       (d_op),
        .d_pc       (d_pc),
        .d_busy0    (d_busy0),
        .d_tag0     (d_tag0),
        .d_val0     (d_val0),
        .d_busy1    (d_busy1),
        .d_tag1     (d_tag1),
        .d_val1     (d_val1),
        .cdb_valid  (cdb_valid),
        .cdb_rs_num (cdb_rs_num),
        .cdb_val    (cdb_val),
        .valid      (valid_vec[gi]),
        .ready      (ready_vec[gi]),
        .op         (op_arr[gi]),
        .pc         (pc_arr[gi]),
        .val0       (val0_arr[gi]),
        .val1       (val1_arr[gi])
      );

      // Per-entry age rank register.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rank_reg[gi] <= '0;
        end else begin
          rank_reg[gi] <= rank_next[gi];
        end
      end
    end
  endgenerate

  // Issue register: loads the selected entry, pulses x_valid for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_valid_reg  <= 1'b0;
      x_rs_num_reg <= '0;
      x_op_reg     <= '0;
      x_pc_reg     <= '0;
      x_val0_reg   <= '0;
      x_val1_reg   <= '0;
    end else if (issue_fire) begin
      x_valid_reg  <= 1'b1;
      x_rs_num_reg <= TAG_W'(RS_BASE) + TAG_W'(sel_idx);
      x_op_reg     <= op_arr[sel_idx];
      x_pc_reg     <= pc_arr[sel_idx];
      x_val0_reg   <= val0_arr[sel_idx];
      x_val1_reg   <= val1_arr[sel_idx];
    end else begin
      x_valid_reg  <= 1'b0;
    end
  end

  assign x_valid  = x_valid_reg;
  assign x_rs_num = x_rs_num_reg;
  assign x_op     = x_op_reg;
  assign x_pc     = x_pc_reg;
  assign x_val0   = x_val0_reg;
  assign x_val1   = x_val1_reg;

endmodule

// File: tb/tb_fxu_sched.sv
// Directed bench for fxu_sched: dispatch, bypass, wakeup, age order, full,
// flush and asynchronous reset, with hand-computed expectations.
module tb_fxu_sched;
  import fxu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        d_valid;
  logic [3:0]  d_op;
  logic [15:0] d_pc;
  logic        d_busy0, d_busy1;
  logic [5:0]  d_tag0, d_tag1;
  logic [15:0] d_val0, d_val1;
  logic        full;
  logic [5:0]  d_rs_num;
  logic        cdb_valid;
  logic [5:0]  cdb_rs_num;
  logic [15:0] cdb_val;
  logic        fxu_busy;
  logic        x_valid;
  logic [5:0]  x_rs_num;
  logic [3:0]  x_op;
  logic [15:0] x_pc;
  logic [15:0] x_val0, x_val1;

  int n_compared = 0;
  int n_mismatched = 0;

  fxu_sched #(.N_ENTRIES(4), .RS_BASE(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .d_valid    (d_valid),
    .d_op       (d_op),
    .d_pc       (d_pc),
    .d_busy0    (d_busy0),
    .d_busy1    (d_busy1),
    .d_tag0     (d_tag0),
    .d_tag1     (d_tag1),
    .d_val0     (d_val0),
    .d_val1     (d_val1),
    .full       (full),
    .d_rs_num   (d_rs_num),
    .cdb_valid  (cdb_valid),
    .cdb_rs_num (cdb_rs_num),
    .cdb_val    (cdb_val),
    .fxu_busy   (fxu_busy),
    .x_valid    (x_valid),
    .x_rs_num   (x_rs_num),
    .x_op       (x_op),
    .x_pc       (x_pc),
    .x_val0     (x_val0),
    .x_val1     (x_val1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] op, input logic [15:0] pc,
                      input logic b0, input logic [5:0] t0, input logic [15:0] v0,
                      input logic b1, input logic [5:0] t1, input logic [15:0] v1);
    d_valid = 1'b1; d_op = op; d_pc = pc;
    d_busy0 = b0; d_tag0 = t0; d_val0 = v0;
    d_busy1 = b1; d_tag1 = t1; d_val1 = v1;
  endtask

  task automatic bcast(input logic [5:0] t, input logic [15:0] v);
    cdb_valid = 1'b1; cdb_rs_num = t; cdb_val = v;
  endtask

  task automatic idle();
    d_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; d_valid = 1'b0; d_op = '0; d_pc = '0;
    d_busy0 = 1'b0; d_busy1 = 1'b0; d_tag0 = '0; d_tag1 = '0; d_val0 = '0; d_val1 = '0;
    cdb_valid = 1'b0; cdb_rs_num = '0; cdb_val = '0; fxu_busy = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_full", 16'(full), 16'h0);
    chk("rst_x_valid", 16'(x_valid), 16'h0);
    chk("rst_x_rs_num", 16'(x_rs_num), 16'h0);
    chk("rst_x_pc", x_pc, 16'h0);
    chk("rst_x_val0", x_val0, 16'h0);
    reset = 1'b0;

    // Ready ADD: issued one cycle after dispatch edge
    disp(OP_ADD, 16'h0010, 1'b0, 6'd0, 16'd3, 1'b0, 6'd0, 16'd4);
    #1;
    chk("t1_d_rs_num", 16'(d_rs_num), 16'h0);
    step(); idle();
    chk("t1_early_x_valid", 16'(x_valid), 16'h0);
    step();
    chk("t1_x_valid", 16'(x_valid), 16'h1);
    chk("t1_x_rs_num", 16'(x_rs_num), 16'h0);
    chk("t1_x_op", 16'(x_op), 16'h1);
    chk("t1_x_val0", x_val0, 16'd3);
    chk("t1_x_val1", x_val1, 16'd4);
    step();
    chk("t1_pulse_end", 16'(x_valid), 16'h0);

    // Wakeup from broadcast two cycles after dispatch
    disp(OP_ADD, 16'h0020, 1'b1, 6'd9, 16'h0, 1'b0, 6'd0, 16'd5);
    step(); idle();
    chk("t2_wait1", 16'(x_valid), 16'h0);
    step();
    chk("t2_wait2", 16'(x_valid), 16'h0);
    bcast(6'd9, 16'h00AA);
    step(); idle();
    chk("t2_wake_edge", 16'(x_valid), 16'h0);
    step();
    chk("t2_x_valid", 16'(x_valid), 16'h1);
    chk("t2_x_val0", x_val0, 16'h00AA);
    chk("t2_x_val1", x_val1, 16'd5);
    chk("t2_x_pc", x_pc, 16'h0020);
    step();
    chk("t2_pulse_end", 16'(x_valid), 16'h0);

    // Fill with FXU busy; 5th dispatch dropped; drain in dispatch order
    fxu_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      disp(OP_ADD, 16'h0300 + 16'(i), 1'b0, 6'd0, 16'(i), 1'b0, 6'd0, 16'h0);
      #1;
      chk("t3_d_rs_num", 16'(d_rs_num), 16'(i));
      step();
      chk("t3_fill_x_valid", 16'(x_valid), 16'h0);
    end
    chk("t3_full", 16'(full), 16'h1);
    disp(OP_ADD, 16'h0355, 1'b0, 6'd0, 16'h55, 1'b0, 6'd0, 16'h0);
    step();
    chk("t3_full_hold", 16'(full), 16'h1);
    fxu_busy = 1'b0;
    step(); idle();
    chk("t3_iss0_valid", 16'(x_valid), 16'h1);
    chk("t3_iss0_rs", 16'(x_rs_num), 16'h0);
    chk("t3_iss0_pc", x_pc, 16'h0300);
    chk("t3_full_after_issue", 16'(full), 16'h0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("t3_iss_valid", 16'(x_valid), 16'h1);
      chk("t3_iss_rs", 16'(x_rs_num), 16'(i));
      chk("t3_iss_pc", x_pc, 16'h0300 + 16'(i));
    end
    step();
    chk("t3_dropped_never_issues", 16'(x_valid), 16'h0);

    // MOV with pending operand 1 still issues
    disp(OP_MOV, 16'h0040, 1'b0, 6'd0, 16'h0077, 1'b1, 6'd5, 16'h0);
    step(); idle();
    step();
    chk("t4_mov_valid", 16'(x_valid), 16'h1);
    chk("t4_mov_op", 16'(x_op), 16'h0);
    chk("t4_mov_val0", x_val0, 16'h0077);
    // ADD whose operands share a tag wakes fully on one broadcast
    disp(OP_ADD, 16'h0041, 1'b1, 6'd7, 16'h0, 1'b1, 6'd7, 16'h0);
    step(); idle();
    chk("t4_add_wait", 16'(x_valid), 16'h0);
    bcast(6'd7, 16'hBEEF);
    step(); idle();
    chk("t4_add_wake_edge", 16'(x_valid), 16'h0);
    step();
    chk("t4_add_valid", 16'(x_valid), 16'h1);
    chk("t4_add_val0", x_val0, 16'hBEEF);
    chk("t4_add_val1", x_val1, 16'hBEEF);
    step();

    // Dispatch bypass from same-cycle broadcast
    disp(OP_ADD, 16'h0050, 1'b1, 6'd12, 16'h0, 1'b0, 6'd0, 16'd1);
    bcast(6'd12, 16'h1234);
    step(); idle();
    chk("t5_bypass_wait", 16'(x_valid), 16'h0);
    step();
    chk("t5_bypass_valid", 16'(x_valid), 16'h1);
    chk("t5_bypass_val0", x_val0, 16'h1234);
    step();

    // Age order beats index order: older entry 1 issues before younger entry 0
    fxu_busy = 1'b1;
    disp(OP_ADD, 16'h0100, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);
    step();
    disp(OP_ADD, 16'h0101, 1'b1, 6'd20, 16'h0, 1'b0, 6'd0, 16'h0);
    #1;
    chk("t6_y_rs", 16'(d_rs_num), 16'h1);
    step(); idle();
    fxu_busy = 1'b0;
    step();
    chk("t6_x_rs", 16'(x_rs_num), 16'h0);
    disp(OP_ADD, 16'h0102, 1'b1, 6'd20, 16'h0, 1'b0, 6'd0, 16'h0);
    #1;
    chk("t6_z_realloc", 16'(d_rs_num), 16'h0);
    step(); idle();
    bcast(6'd20, 16'h0020);
    step(); idle();
    step();
    chk("t6_old_first_rs", 16'(x_rs_num), 16'h1);
    chk("t6_old_first_pc", x_pc, 16'h0101);
    step();
    chk("t6_young_valid", 16'(x_valid), 16'h1);
    chk("t6_young_rs", 16'(x_rs_num), 16'h0);
    chk("t6_young_pc", x_pc, 16'h0102);
    step();

    // Flush with 3 valid entries and a concurrent dispatch and issue opportunity
    fxu_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      disp(OP_ADD, 16'h0700 + 16'(i), 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);
      step();
    end
    disp(OP_ADD, 16'h07FF, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);
    flush = 1'b1;
    fxu_busy = 1'b0;
    step(); idle();
    chk("t7_full", 16'(full), 16'h0);
    chk("t7_x_valid", 16'(x_valid), 16'h0);
    chk("t7_d_rs_num", 16'(d_rs_num), 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t7_no_issue", 16'(x_valid), 16'h0);
    end

    // Asynchronous reset while an issue is on x_*
    disp(OP_ADD, 16'h0900, 1'b0, 6'd0, 16'h0009, 1'b0, 6'd0, 16'h0);
    step(); idle();
    step();
    chk("t8_issue_valid", 16'(x_valid), 16'h1);
    reset = 1'b1;
    #1;
    chk("t8_async_x_valid", 16'(x_valid), 16'h0);
    chk("t8_async_x_val0", x_val0, 16'h0);
    step();
    reset = 1'b0;
    step();
    chk("t8_after_reset", 16'(x_valid), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
